// File: rtl/uart_tx_arbiter_if.sv
// Requester / UART_TX handshake bundle for uart_tx_arbiter.
// The arbiter uses the slave modport; requesters and the transmitter sit on the master side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]      REQ_VLD;
    logic [NUM_REQ-1:0][7:0] REQ_DATA;
    logic [NUM_REQ-1:0]      REQ_LAST;
    logic [NUM_REQ-1:0]      REQ_RDY;
    logic                    TX_BUSY;
    logic                    TX_START;
    logic [7:0]              TX_DATA;
    logic [NUM_REQ-1:0]      GRANT;
    logic                    ARB_TIMEOUT;

    modport master (
        output REQ_VLD, REQ_DATA, REQ_LAST, TX_BUSY,
        input  REQ_RDY, TX_START, TX_DATA, GRANT, ARB_TIMEOUT
    );

    modport slave (
        input  REQ_VLD, REQ_DATA, REQ_LAST, TX_BUSY,
        output REQ_RDY, TX_START, TX_DATA, GRANT, ARB_TIMEOUT
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular arbiter sharing one UART_TX byte transmitter between NUM_REQ requesters.
// Define UART_TX_ARB_PRIO_EN to give requester 0 fixed priority; the others stay round-robin.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int IDLE_TIMEOUT = 1000000
) (
    input logic              CLK_100M,
    input logic              SYS_RST,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(IDLE_TIMEOUT);

    typedef logic [IW-1:0] idx_t;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    idx_t               owner_q, owner_d;
    idx_t               ptr_q, ptr_d;
    idx_t               win_idx, nxt_ptr;
    logic               win_vld;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] rdy_q, rdy_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               to_q, to_d;

    // Winner search: the lowest offset from the pointer wins, so scan high-to-low and overwrite.
    always_comb begin
        int   c;
        idx_t ci;
        win_vld = 1'b0;
        win_idx = '0;
        c       = 0;
        ci      = '0;
`ifdef UART_TX_ARB_PRIO_EN
        begin
            int base;
            base = (ptr_q == '0) ? 1 : int'(ptr_q);
            for (int k = NUM_REQ - 2; k >= 0; k--) begin
                c  = 1 + (base - 1 + k) % (NUM_REQ - 1);
                ci = idx_t'(c);
                if (bus.REQ_VLD[ci]) begin
                    win_vld = 1'b1;
                    win_idx = ci;
                end
            end
            if (bus.REQ_VLD[0]) begin
                win_vld = 1'b1;
                win_idx = '0;
            end
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c  = (int'(ptr_q) + k) % NUM_REQ;
            ci = idx_t'(c);
            if (bus.REQ_VLD[ci]) begin
                win_vld = 1'b1;
                win_idx = ci;
            end
        end
`endif
    end

    // Pointer to use once the current owner releases the transmitter.
    always_comb begin
`ifdef UART_TX_ARB_PRIO_EN
        if (owner_q == '0)
            nxt_ptr = ptr_q;
        else if (int'(owner_q) == NUM_REQ - 1)
            nxt_ptr = idx_t'(1);
        else
            nxt_ptr = owner_q + 1'b1;
`else
        nxt_ptr = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
`endif
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        grant_d    = grant_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        rdy_d      = '0;
        to_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    owner_d          = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    cnt_d            = '0;
                    state_d          = LOAD;
                end
            end
            LOAD: begin
                if (bus.REQ_VLD[owner_q]) begin
                    tx_data_d      = bus.REQ_DATA[owner_q];
                    tx_start_d     = 1'b1;
                    rdy_d[owner_q] = 1'b1;
                    last_d         = bus.REQ_LAST[owner_q];
                    cnt_d          = '0;
                    state_d        = WAIT_BUSY;
                end else if (cnt_q == CW'(IDLE_TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    grant_d = '0;
                    ptr_d   = nxt_ptr;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_BUSY: begin
                if (bus.TX_BUSY) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.TX_BUSY) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = nxt_ptr;
                        state_d = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_100M) begin
        if (SYS_RST) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            grant_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            rdy_q      <= '0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            rdy_q      <= rdy_d;
            to_q       <= to_d;
        end
    end

    assign bus.REQ_RDY     = rdy_q;
    assign bus.TX_START    = tx_start_q;
    assign bus.TX_DATA     = tx_data_q;
    assign bus.GRANT       = grant_q;
    assign bus.ARB_TIMEOUT = to_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed table, timing sequences, and packet runs
// scored against a packet-level round-robin reference.
module tb_uart_tx_arbiter;
    localparam int NR = 2;
    localparam int TO = 16;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         stall;
    } byte_t;

    typedef struct {
        logic [1:0] mask;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] exp_grant;
        logic [7:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NR), .IDLE_TIMEOUT(TO)) dut (
        .CLK_100M (clk),
        .SYS_RST  (rst),
        .bus      (bus)
    );

    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    byte_t req_q [NR][$];
    int    line_q [$];
    int    exp_q [$];
    int    mptr        = 0;
    logic  busy_pend   = 1'b0;
    int    busy_left   = 0;
    int    busy_len    = 10;
    int    fall_cyc    = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic int gidx(input logic [NR-1:0] g);
        int r = -1;
        for (int i = 0; i < NR; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic bit q_empty();
        for (int i = 0; i < NR; i++) if (req_q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: observe outputs, model UART_TX busy, then update requester drives.
    task automatic step();
        byte_t b;
        @(negedge clk);
        cyc++;
        if (bus.TX_START === 1'b1) begin
            chk("start_while_busy", 32'(bus.TX_BUSY), 32'd0);
            line_q.push_back(gidx(bus.GRANT) * 256 + int'(bus.TX_DATA));
            busy_pend = 1'b1;
        end else if (busy_pend) begin
            busy_pend   = 1'b0;
            bus.TX_BUSY = 1'b1;
            busy_left   = busy_len;
        end else if (bus.TX_BUSY) begin
            busy_left--;
            if (busy_left <= 0) begin
                bus.TX_BUSY = 1'b0;
                fall_cyc    = cyc;
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (bus.REQ_RDY[i] === 1'b1 && req_q[i].size() > 0) void'(req_q[i].pop_front());
            bus.REQ_VLD[i]  = 1'b0;
            bus.REQ_DATA[i] = 8'h00;
            bus.REQ_LAST[i] = 1'b0;
            if (req_q[i].size() > 0) begin
                b = req_q[i][0];
                if (b.stall > 0) begin
                    b.stall--;
                    req_q[i][0] = b;
                end else begin
                    bus.REQ_VLD[i]  = 1'b1;
                    bus.REQ_DATA[i] = b.data;
                    bus.REQ_LAST[i] = b.last;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) req_q[i].delete();
        step();
        step();
        rst  = 1'b0;
        mptr = 0;
    endtask

    task automatic add_pkt(input int r, input string s);
        for (int k = 0; k < s.len(); k++)
            req_q[r].push_back('{s[k], (k == s.len() - 1), 0});
    endtask

    task automatic add_rand_pkt(input int r, input int len, input bit stalls);
        for (int k = 0; k < len; k++)
            req_q[r].push_back('{8'($urandom), (k == len - 1),
                                 (stalls && k > 0) ? int'($urandom_range(0, 3)) : 0});
    endtask

    // Reference: whole packets leave in round-robin order over requesters that still have data.
    task automatic model_expect();
        byte_t cq [NR][$];
        byte_t b;
        int    g;
        for (int i = 0; i < NR; i++) cq[i] = req_q[i];
        exp_q.delete();
        forever begin
            g = -1;
            for (int k = 0; k < NR; k++) begin
                if (cq[(mptr + k) % NR].size() > 0) begin
                    g = (mptr + k) % NR;
                    break;
                end
            end
            if (g < 0) break;
            do begin
                b = cq[g].pop_front();
                exp_q.push_back(g * 256 + int'(b.data));
            end while (!b.last && cq[g].size() > 0);
            mptr = (g + 1) % NR;
        end
    endtask

    task automatic wait_done(input string name, input int n_exp, input int budget);
        int k = 0;
        while (k < budget && !(line_q.size() >= n_exp && bus.GRANT == '0 &&
                               !bus.TX_BUSY && !busy_pend && q_empty())) begin
            step();
            k++;
        end
        if (k >= budget) chk({name, "_budget"}, 32'd0, 32'd1);
    endtask

    task automatic run_pkts(input string name);
        line_q.delete();
        model_expect();
        wait_done(name, exp_q.size(), 6000);
        chk({name, "_count"}, line_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < line_q.size(); k++)
            chk($sformatf("%s_byte%0d", name, k), line_q[k], exp_q[k]);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, want $finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [7];
        int   okfail [7];
        int   k;
        int   to_cyc;

        tbl[0] = '{2'b01, 8'h4F, 8'h00, 2'b01, 8'h4F};
        tbl[1] = '{2'b11, 8'h11, 8'h22, 2'b10, 8'h22};
        tbl[2] = '{2'b11, 8'h33, 8'h44, 2'b01, 8'h33};
        tbl[3] = '{2'b01, 8'h55, 8'h00, 2'b01, 8'h55};
        tbl[4] = '{2'b10, 8'h00, 8'h66, 2'b10, 8'h66};
        tbl[5] = '{2'b10, 8'h00, 8'h77, 2'b10, 8'h77};
        tbl[6] = '{2'b11, 8'h88, 8'h99, 2'b01, 8'h88};
        okfail = '{32'h04F, 32'h04B, 32'h00D, 32'h146, 32'h141, 32'h149, 32'h14C};

        bus.TX_BUSY  = 1'b0;
        bus.REQ_VLD  = '0;
        bus.REQ_DATA = '0;
        bus.REQ_LAST = '0;

        do_reset();
        chk("reset_outputs",
            32'({bus.REQ_RDY, bus.TX_START, bus.TX_DATA, bus.GRANT, bus.ARB_TIMEOUT}), 32'd0);

        // Single-byte packets: grant at +1, start at +2, release one cycle after busy falls.
        busy_len = 10;
        for (int t = 0; t < 7; t++) begin
            line_q.delete();
            if (tbl[t].mask[0]) req_q[0].push_back('{tbl[t].d0, 1'b1, 0});
            if (tbl[t].mask[1]) req_q[1].push_back('{tbl[t].d1, 1'b1, 0});
            step();
            step();
            chk($sformatf("t%0d_grant", t), 32'(bus.GRANT), 32'(tbl[t].exp_grant));
            chk($sformatf("t%0d_start_early", t), 32'(bus.TX_START), 32'd0);
            step();
            chk($sformatf("t%0d_start", t), 32'(bus.TX_START), 32'd1);
            chk($sformatf("t%0d_rdy", t), 32'(bus.REQ_RDY), 32'(tbl[t].exp_grant));
            chk($sformatf("t%0d_data", t), 32'(bus.TX_DATA), 32'(tbl[t].exp_data));
            for (int i = 0; i < NR; i++) req_q[i].delete();
            fall_cyc = -1;
            k = 0;
            while (fall_cyc < 0 && k < 60) begin
                step();
                k++;
            end
            chk($sformatf("t%0d_grant_held", t), 32'(bus.GRANT), 32'(tbl[t].exp_grant));
            step();
            chk($sformatf("t%0d_grant_clr", t), 32'(bus.GRANT), 32'd0);
        end

        // Simultaneous packets, then the same request again.
        do_reset();
        add_pkt(0, "OK\r");
        add_pkt(1, "FAIL");
        run_pkts("okfail");
        for (int j = 0; j < 7; j++)
            chk($sformatf("okfail_line%0d", j), (j < line_q.size()) ? line_q[j] : -1, okfail[j]);
        add_pkt(0, "OK\r");
        add_pkt(1, "FAIL");
        run_pkts("okfail_rpt");

        // Stalled owner loses its grant after IDLE_TIMEOUT cycles in LOAD.
        do_reset();
        line_q.delete();
        req_q[1].push_back('{8'hA1, 1'b0, 0});
        step();
        step();
        chk("to_grant1", 32'(bus.GRANT), 32'd2);
        step();
        chk("to_start", 32'({bus.TX_START, bus.TX_DATA}), 32'h1A1);
        req_q[0].push_back('{8'h5A, 1'b1, 0});
        fall_cyc = -1;
        k = 0;
        while (fall_cyc < 0 && k < 60) begin
            step();
            k++;
        end
        to_cyc = -1;
        k = 0;
        while (to_cyc < 0 && k < 40) begin
            step();
            k++;
            if (bus.ARB_TIMEOUT === 1'b1) to_cyc = cyc;
        end
        chk("to_latency", to_cyc - fall_cyc, 32'd17);
        chk("to_grant_clr", 32'(bus.GRANT), 32'd0);
        step();
        chk("to_pulse_width", 32'(bus.ARB_TIMEOUT), 32'd0);
        chk("to_next_grant", 32'(bus.GRANT), 32'd1);
        wait_done("to_tail", 2, 200);
        chk("to_tail_byte", (line_q.size() > 1) ? line_q[1] : -1, 32'h05A);

        // Reset while the first byte of a 3-byte packet is on the line.
        do_reset();
        line_q.delete();
        add_pkt(0, "ABC");
        k = 0;
        while (!bus.TX_BUSY && k < 30) begin
            step();
            k++;
        end
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) req_q[i].delete();
        step();
        chk("midrst_outputs",
            32'({bus.REQ_RDY, bus.TX_START, bus.TX_DATA, bus.GRANT, bus.ARB_TIMEOUT}), 32'd0);
        rst  = 1'b0;
        mptr = 0;
        repeat (40) step();
        chk("midrst_starts", line_q.size(), 32'd1);

        // Back-to-back packets from both requesters must alternate owners.
        do_reset();
        busy_len = 10;
        for (int p = 0; p < 10; p++) begin
            add_rand_pkt(0, $urandom_range(1, 4), 1'b0);
            add_rand_pkt(1, $urandom_range(1, 4), 1'b0);
        end
        run_pkts("alt20");

        // Random packet mixes with mid-packet stalls and varied transmitter timing.
        for (int it = 0; it < 4; it++) begin
            busy_len = $urandom_range(2, 12);
            for (int r = 0; r < NR; r++) begin
                int np = $urandom_range(1, 5);
                for (int p = 0; p < np; p++) add_rand_pkt(r, $urandom_range(1, 5), 1'b1);
            end
            run_pkts($sformatf("rand%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
